// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, CLR, WAIT_LOW} rx_fifo_state_t;

    localparam int UART_N        = 8;
    localparam int RX_FIFO_DEPTH = 16;
    localparam int CLKS_PER_BIT  = 434;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push is accepted when full if a pop happens on the same edge.
module sync_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [N-1:0]             wr_data,
    input  logic                     pop,
    output logic [N-1:0]             rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset && do_push)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// Captures each UART byte into a FIFO and returns the ready_clr handshake; flags dropped bytes.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int N     = UART_N,
    parameter int DEPTH = RX_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_ready,
    input  logic [N-1:0]             rx_data,
    output logic                     rx_ready_clr,
    input  logic                     rd_en,
    output logic [N-1:0]             rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);
    localparam int AW = $clog2(DEPTH);

    rx_fifo_state_t state, state_nxt;
    logic           push_req, drop;
    logic [AW:0]    occ;

    assign push_req = (state == IDLE) && rx_ready;
    assign drop     = push_req && full && !rd_en;
    assign count    = occ;

    sync_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_req),
        .wr_data (rx_data),
        .pop     (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (occ)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // WAIT_LOW keeps a slow-falling ready from being captured twice.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (rx_ready)  state_nxt = CLR;
            CLR:                     state_nxt = WAIT_LOW;
            WAIT_LOW: if (!rx_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rx_ready_clr = (state == CLR);
    end

    // A drop on the same edge as ovf_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset)        overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: stimulus queues expected bytes, a negedge monitor checks every pop.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_ready_clr;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full, overflow;
    logic       ovf_clr = 1'b0;
    logic [4:0] count;

    int errors = 0;
    int checks = 0;
    int clr_cnt = 0;
    logic [7:0] exp_q [$];

    always #10 clk = ~clk;

    uart_rx_fifo dut (
        .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_ready_clr(rx_ready_clr), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .full(full), .count(count), .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) if (rx_ready_clr) clr_cnt++;

    always @(negedge clk) begin
        if (!reset && rd_en && !empty) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %02h expected nothing", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %02h expected %02h", rd_data, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Behaves like the UART receiver: raise ready, release it once ready_clr is seen.
    task automatic send_byte(input logic [7:0] b, input bit captured, input bit with_rd);
        bit seen = 0;
        rx_data  = b;
        rx_ready = 1'b1;
        rd_en    = with_rd;
        if (captured) exp_q.push_back(b);
        for (int i = 0; i < 10 && !seen; i++) begin
            tick(1);
            rd_en = 1'b0;
            if (rx_ready_clr) seen = 1;
        end
        if (!seen) check("clr_timeout", 0, 1);
        rx_ready = 1'b0;
        tick(3);
    endtask

    task automatic drain(input int n);
        rd_en = 1'b1;
        tick(n);
        rd_en = 1'b0;
        tick(1);
    endtask

    initial begin
        int c0;
        logic [3:0] rp, wp;
        tick(3);
        reset = 1'b0;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_clr", rx_ready_clr, 0);

        // Four bytes with no reads, then drain in order.
        c0 = clr_cnt;
        send_byte(8'hAA, 1, 0);
        check("first_head", rd_data, 8'hAA);
        send_byte(8'hFF, 1, 0);
        send_byte(8'hDA, 1, 0);
        send_byte(8'h00, 1, 0);
        check("four_count", count, 4);
        check("four_clr", clr_cnt - c0, 4);
        drain(4);
        check("four_empty", empty, 1);

        // Ready held high for 10 cycles: one push, one pulse.
        c0 = clr_cnt;
        rx_data = 8'h42; rx_ready = 1'b1;
        exp_q.push_back(8'h42);
        tick(10);
        check("hold_state", dut.state == WAIT_LOW, 1);
        check("hold_count", count, 1);
        check("hold_clr", clr_cnt - c0, 1);
        rx_ready = 1'b0;
        tick(1);
        check("hold_idle", dut.state == IDLE, 1);
        drain(1);

        // Fill, then overflow.
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), 1, 0);
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        c0 = clr_cnt;
        send_byte(8'h5C, 0, 0);
        check("drop_ovf", overflow, 1);
        check("drop_count", count, 16);
        check("drop_clr", clr_cnt - c0, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full with read on the capture edge: pop old head, append new byte.
        send_byte(8'h77, 1, 1);
        check("fullrw_count", count, 16);
        check("fullrw_ovf", overflow, 0);
        check("fullrw_head", rd_data, 8'h11);
        drain(16);
        check("fullrw_empty", empty, 1);

        // Reads while empty are ignored.
        rp = dut.u_fifo.rd_ptr; wp = dut.u_fifo.wr_ptr;
        drain(3);
        check("emptyrd_count", count, 0);
        check("emptyrd_rptr", dut.u_fifo.rd_ptr, rp);
        check("emptyrd_wptr", dut.u_fifo.wr_ptr, wp);
        send_byte(8'h3C, 1, 0);
        send_byte(8'hC3, 1, 0);
        drain(2);

        // Reset during CLR with 3 entries stored.
        send_byte(8'h01, 1, 0);
        send_byte(8'h02, 1, 0);
        send_byte(8'h03, 1, 0);
        rx_data = 8'h04; rx_ready = 1'b1;
        tick(1);
        check("pre_rst_clr_state", dut.state == CLR, 1);
        reset = 1'b1;
        exp_q.delete();
        tick(1);
        check("midrst_count", count, 0);
        check("midrst_empty", empty, 1);
        check("midrst_clr", rx_ready_clr, 0);
        check("midrst_state", dut.state == IDLE, 1);
        reset = 1'b0;
        rx_ready = 1'b0;
        send_byte(8'h04, 1, 0);
        check("postrst_count", count, 1);
        drain(1);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
